odesa_wta_threshold: RTL and testbench

//  Downstream stage of the 4-input winner-take-all comparator in the ODESA neuron layer.

---
 rtl/odesa_wta_threshold.sv | 149 ++++++++++++++
 tb/tb_odesa_wta_threshold.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/odesa_wta_threshold.sv
// odesa_wta_threshold: adaptive-threshold spike stage behind the 4-input WTA comparator.
// Tests the winner against its own threshold, learns toward the winner, decays on silence.
//
// Ports:
//   i_clk, i_rst      clock, synchronous active-high reset
//   i_valid           comparator result valid (1-cycle pulse)
//   i_index           one-hot winner index
//   i_result          winner potential
//   i_learn           learning enable, sampled with i_valid
//   o_ready           high while idle; only then is i_valid accepted
//   o_spike           1-cycle spike pulse, o_spike_id holds the neuron id
//   o_err             1-cycle pulse: accepted index was zero or not one-hot
//   o_drop            1-cycle pulse: i_valid arrived while busy
//   o_thr             thresholds {thr3,thr2,thr1,thr0}
module odesa_wta_threshold #(
    parameter int p_width    = 19,
    parameter int p_thr_init = 1024,
    parameter int p_thr_min  = 64,
    parameter int p_eta_sh   = 3,
    parameter int p_dec_sh   = 4,
    parameter int p_timeout  = 1000,
    parameter int p_tw       = 10
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_valid,
    input  logic [3:0]           i_index,
    input  logic [p_width-1:0]   i_result,
    input  logic                 i_learn,
    output logic                 o_ready,
    output logic                 o_spike,
    output logic [1:0]           o_spike_id,
    output logic                 o_err,
    output logic                 o_drop,
    output logic [4*p_width-1:0] o_thr
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CHECK,
        S_UPDATE,
        S_DECAY
    } state_t;

    localparam logic [p_width-1:0] THR_INIT = p_width'(p_thr_init);
    localparam logic [p_width-1:0] THR_MIN  = p_width'(p_thr_min);
    localparam logic [p_tw-1:0]    TIMEOUT  = p_tw'(p_timeout);

    state_t                    state;
    logic [3:0][p_width-1:0]   thr;
    logic [1:0]                cap_id;
    logic [p_width-1:0]        cap_pot;
    logic                      cap_learn;
    logic [p_tw-1:0]           cnt;

    logic                      idx_onehot;
    logic [1:0]                idx_enc;
    logic [p_width-1:0]        thr_sel;
    logic [p_width-1:0]        thr_learn;
    logic [3:0][p_width-1:0]   thr_dec;

    assign o_ready = (state == S_IDLE);
    assign o_thr   = thr;

    always_comb begin
        idx_onehot = $onehot(i_index);
        if (i_index[3])      idx_enc = 2'd3;
        else if (i_index[2]) idx_enc = 2'd2;
        else if (i_index[1]) idx_enc = 2'd1;
        else                 idx_enc = 2'd0;
    end

    // UPDATE is only reached after a spike, so cap_pot >= thr_sel there
    // and the difference never wraps.
    always_comb begin
        thr_sel   = thr[cap_id];
        thr_learn = thr_sel + ((cap_pot - thr_sel) >> p_eta_sh);
    end

    always_comb begin
        thr_dec = thr;
        for (int k = 0; k < 4; k++) begin
            thr_dec[k] = thr[k] - (thr[k] >> p_dec_sh);
            if (thr_dec[k] < THR_MIN) thr_dec[k] = THR_MIN;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state      <= S_IDLE;
            thr        <= {4{THR_INIT}};
            cap_id     <= '0;
            cap_pot    <= '0;
            cap_learn  <= 1'b0;
            cnt        <= '0;
            o_spike    <= 1'b0;
            o_spike_id <= '0;
            o_err      <= 1'b0;
            o_drop     <= 1'b0;
        end else begin
            o_spike <= 1'b0;
            o_err   <= 1'b0;
            o_drop  <= 1'b0;

            // Saturating idle counter; spike and decay override below.
            if (cnt < TIMEOUT) cnt <= cnt + 1'b1;

            if (i_valid && state != S_IDLE) o_drop <= 1'b1;

            unique case (state)
                S_IDLE: begin
                    if (i_valid) begin
                        if (idx_onehot) begin
                            cap_id    <= idx_enc;
                            cap_pot   <= i_result;
                            cap_learn <= i_learn;
                            state     <= S_CHECK;
                        end else begin
                            o_err <= 1'b1;
                        end
                    end else if (cnt >= TIMEOUT) begin
                        state <= S_DECAY;
                    end
                end
                S_CHECK: begin
                    if (cap_pot >= thr_sel) begin
                        o_spike    <= 1'b1;
                        o_spike_id <= cap_id;
                        cnt        <= '0;
                        state      <= cap_learn ? S_UPDATE : S_IDLE;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_UPDATE: begin
                    thr[cap_id] <= thr_learn;
                    state       <= S_IDLE;
                end
                S_DECAY: begin
                    thr   <= thr_dec;
                    cnt   <= '0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_odesa_wta_threshold.sv
// tb_odesa_wta_threshold: directed bench for odesa_wta_threshold.
// Spike ids expected by the stimulus are queued and matched as spikes appear.
module tb_odesa_wta_threshold;

    localparam int W = 19;

    logic           clk = 1'b0;
    logic           i_rst;
    logic           i_valid;
    logic [3:0]     i_index;
    logic [W-1:0]   i_result;
    logic           i_learn;
    logic           o_ready;
    logic           o_spike;
    logic [1:0]     o_spike_id;
    logic           o_err;
    logic           o_drop;
    logic [4*W-1:0] o_thr;

    int n_vec = 0;
    int n_mis = 0;
    int exp_q[$];

    always #5 clk = ~clk;

    odesa_wta_threshold dut (
        .i_clk      (clk),
        .i_rst      (i_rst),
        .i_valid    (i_valid),
        .i_index    (i_index),
        .i_result   (i_result),
        .i_learn    (i_learn),
        .o_ready    (o_ready),
        .o_spike    (o_spike),
        .o_spike_id (o_spike_id),
        .o_err      (o_err),
        .o_drop     (o_drop),
        .o_thr      (o_thr)
    );

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [4*W-1:0] thr4(input int t3, input int t2,
                                            input int t1, input int t0);
        return {W'(t3), W'(t2), W'(t1), W'(t0)};
    endfunction

    // Scoreboard side: every observed spike must match the oldest queued id.
    always @(negedge clk) begin
        if (o_spike) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_spike", 128'(o_spike_id), 128'd99);
            end else begin
                chk("spike_id_sb", 128'(o_spike_id), 128'(exp_q.pop_front()));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        i_rst = 1'b1;
        @(posedge clk);
        #1 i_rst = 1'b0;
    endtask

    // Presents one valid cycle; returns #1 after the accepting edge N.
    task automatic send(input logic [3:0] idx, input int pot, input logic lrn,
                        input int spike_id);
        @(negedge clk);
        i_valid  = 1'b1;
        i_index  = idx;
        i_result = W'(pot);
        i_learn  = lrn;
        if (spike_id >= 0) exp_q.push_back(spike_id);
        @(posedge clk);
        #1 i_valid = 1'b0;
    endtask

    initial begin
        bit reached;
        i_rst    = 1'b0;
        i_valid  = 1'b0;
        i_index  = '0;
        i_result = '0;
        i_learn  = 1'b0;

        // Reset state and quiet idle cycles
        do_reset();
        chk("rst_thr", 128'(o_thr), 128'(thr4(1024, 1024, 1024, 1024)));
        chk("rst_ready", 128'(o_ready), 128'd1);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("idle_spike", 128'(o_spike), 128'd0);
        end

        // Spike with learning on neuron 1
        send(4'b0010, 2048, 1'b1, 1);
        chk("t2_ready_busy", 128'(o_ready), 128'd0);
        step();
        chk("t2_spike", 128'(o_spike), 128'd1);
        chk("t2_spike_id", 128'(o_spike_id), 128'd1);
        chk("t2_thr_pre", 128'(o_thr), 128'(thr4(1024, 1024, 1024, 1024)));
        step();
        chk("t2_spike_end", 128'(o_spike), 128'd0);
        chk("t2_thr1", 128'(o_thr), 128'(thr4(1024, 1024, 1152, 1024)));

        // Sub-threshold event, then a malformed index
        send(4'b0001, 1000, 1'b1, -1);
        step();
        chk("t3_nospike", 128'(o_spike), 128'd0);
        step();
        chk("t3_thr", 128'(o_thr), 128'(thr4(1024, 1024, 1152, 1024)));
        send(4'b0110, 5000, 1'b1, -1);
        chk("t3_err", 128'(o_err), 128'd1);
        chk("t3_err_ready", 128'(o_ready), 128'd1);
        step();
        chk("t3_err_end", 128'(o_err), 128'd0);
        step();
        chk("t3_err_thr", 128'(o_thr), 128'(thr4(1024, 1024, 1152, 1024)));

        // One decay step after exactly the timeout, then clamp at the floor
        do_reset();
        repeat (1000) @(posedge clk);
        #1;
        chk("t4_thr_pre", 128'(o_thr), 128'(thr4(1024, 1024, 1024, 1024)));
        step();
        chk("t4_decay_busy", 128'(o_ready), 128'd0);
        step();
        chk("t4_thr_dec", 128'(o_thr), 128'(thr4(960, 960, 960, 960)));
        reached = 1'b0;
        for (int i = 0; i < 60000 && !reached; i++) begin
            step();
            if (o_thr == thr4(64, 64, 64, 64)) reached = 1'b1;
        end
        chk("t4_floor_reached", 128'(reached), 128'd1);
        repeat (2100) @(posedge clk);
        #1;
        chk("t4_floor_hold", 128'(o_thr), 128'(thr4(64, 64, 64, 64)));

        // Valid during CHECK is dropped; the original event still spikes
        do_reset();
        @(negedge clk);
        i_valid  = 1'b1;
        i_index  = 4'b0100;
        i_result = W'(3000);
        i_learn  = 1'b0;
        exp_q.push_back(2);
        step();
        i_index  = 4'b0001;
        i_result = W'(9000);
        step();
        i_valid = 1'b0;
        chk("t5_spike", 128'(o_spike), 128'd1);
        chk("t5_spike_id", 128'(o_spike_id), 128'd2);
        chk("t5_drop", 128'(o_drop), 128'd1);
        step();
        chk("t5_drop_end", 128'(o_drop), 128'd0);
        chk("t5_no_second", 128'(o_spike), 128'd0);

        // Saturate the counter while kept busy with malformed valids
        @(negedge clk);
        i_valid = 1'b1;
        i_index = 4'b0000;
        repeat (1010) @(posedge clk);
        #1;
        chk("t5_sat_err", 128'(o_err), 128'd1);
        chk("t5_sat_thr", 128'(o_thr), 128'(thr4(1024, 1024, 1024, 1024)));
        // Potential exactly at threshold still spikes and clears the counter
        send(4'b1000, 1024, 1'b0, 3);
        step();
        chk("t5_sat_spike", 128'(o_spike), 128'd1);
        chk("t5_sat_spike_id", 128'(o_spike_id), 128'd3);
        repeat (900) @(posedge clk);
        #1;
        chk("t5_no_decay", 128'(o_thr), 128'(thr4(1024, 1024, 1024, 1024)));
        chk("t5_idle_ready", 128'(o_ready), 128'd1);

        // Reset landing on the UPDATE cycle discards the update
        send(4'b0001, 4096, 1'b1, 0);
        step();
        chk("t6_spike", 128'(o_spike), 128'd1);
        i_rst = 1'b1;
        step();
        i_rst = 1'b0;
        chk("t6_thr_rst", 128'(o_thr), 128'(thr4(1024, 1024, 1024, 1024)));
        chk("t6_ready", 128'(o_ready), 128'd1);
        chk("t6_spike_clr", 128'(o_spike), 128'd0);
        step();
        chk("t6_thr_hold", 128'(o_thr), 128'(thr4(1024, 1024, 1024, 1024)));

        chk("sb_drained", 128'(exp_q.size()), 128'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
